// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall sequencing, redirect flushes,
// and saturating stall/flush performance counters.
//
// Ports:
//   i_hazard_clk, i_hazard_reset      clock, synchronous active-high reset
//   i_hazard_rs1/rs2_addr_decode      source registers of the decode instruction
//   i_hazard_rd_addr_ex/_rd_wren_ex   destination and write enable in ID/EX
//   i_hazard_wb_sel_ex                writeback select in ID/EX (marks loads)
//   i_hazard_br_taken_ex              execute resolved a redirect
//   o_hazard_pc/fetch/decode_stall    hold PC / hold IF/ID / bubble into ID/EX
//   o_hazard_fetch/decode_flush       clear IF/ID / clear ID/EX
//   o_hazard_state                    FSM state (debug)
//   o_hazard_stall_cnt/_flush_cnt     saturating stall-cycle / redirect counts
module hazard_control #(
   parameter int         LOAD_STALL_CYCLES = 1,
   parameter logic [1:0] LOAD_WB_SEL       = 2'b10,
   parameter int         CNT_W             = 32
) (
   input  logic             i_hazard_clk,
   input  logic             i_hazard_reset,
   input  logic [4:0]       i_hazard_rs1_addr_decode,
   input  logic [4:0]       i_hazard_rs2_addr_decode,
   input  logic [4:0]       i_hazard_rd_addr_ex,
   input  logic             i_hazard_rd_wren_ex,
   input  logic [1:0]       i_hazard_wb_sel_ex,
   input  logic             i_hazard_br_taken_ex,
   output logic             o_hazard_pc_stall,
   output logic             o_hazard_fetch_stall,
   output logic             o_hazard_decode_stall,
   output logic             o_hazard_fetch_flush,
   output logic             o_hazard_decode_flush,
   output logic [1:0]       o_hazard_state,
   output logic [CNT_W-1:0] o_hazard_stall_cnt,
   output logic [CNT_W-1:0] o_hazard_flush_cnt
);

   localparam logic [1:0] S_IDLE       = 2'b00;
   localparam logic [1:0] S_LOAD_STALL = 2'b01;
   localparam logic [1:0] S_FLUSH      = 2'b10;
   localparam logic [3:0] REM_INIT     = 4'(LOAD_STALL_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       remaining_q, remaining_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;
   logic             stall;
   logic             flush;

   assign load_use = i_hazard_rd_wren_ex
                  && (i_hazard_wb_sel_ex == LOAD_WB_SEL)
                  && (i_hazard_rd_addr_ex != 5'd0)
                  && ((i_hazard_rd_addr_ex == i_hazard_rs1_addr_decode)
                   || (i_hazard_rd_addr_ex == i_hazard_rs2_addr_decode));

   // State register
   always_ff @(posedge i_hazard_clk) begin
      if (i_hazard_reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d     = S_IDLE;
      remaining_d = '0;
      unique case (state_q)
         S_LOAD_STALL: begin
            // ID/EX holds a bubble here, so load_use is ignored
            if (i_hazard_br_taken_ex) begin
               state_d = S_FLUSH;
            end else if (remaining_q > 4'd1) begin
               state_d     = S_LOAD_STALL;
               remaining_d = remaining_q - 4'd1;
            end
         end
         default: begin
            if (i_hazard_br_taken_ex) begin
               state_d = S_FLUSH;
            end else if (load_use && (REM_INIT != 4'd0)) begin
               state_d     = S_LOAD_STALL;
               remaining_d = REM_INIT;
            end
         end
      endcase
   end

   // Outputs; a redirect squashes the dependent instruction, so flush wins
   always_comb begin
      flush = !i_hazard_reset && i_hazard_br_taken_ex;
      stall = !i_hazard_reset && !i_hazard_br_taken_ex
           && ((state_q == S_LOAD_STALL) || load_use);
      o_hazard_pc_stall     = stall;
      o_hazard_fetch_stall  = stall;
      o_hazard_decode_stall = stall;
      o_hazard_fetch_flush  = flush;
      o_hazard_decode_flush = flush;
      o_hazard_state        = state_q;
   end

   // Saturating counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   assign o_hazard_stall_cnt = stall_cnt_q;
   assign o_hazard_flush_cnt = flush_cnt_q;

endmodule
